game_sequencer: RTL and testbench
=================================

# game_sequencer

Round/phase controller for Crossy Robbers. It runs on the 50 MHz system clock and derives a frame tick from VGA vertical sync. It steps the game through title, countdown, play, round-end and game-over phases, and gates object motion for the game logic. It also keeps the round timer and per-player round wins, and drives the BCD values shown on the HEX displays.

## Interface
Parameters:
- FRAMES_PER_SEC, 60: frame ticks per timer second (1..255).
- COUNTDOWN_SECS, 3: pre-round countdown (1..9).
- ROUND_SECS, 60: round length in seconds (1..99).
- ENDWAIT_SECS, 2: auto-advance delay after a round (1..9).
- ROUNDS, 3: rounds per match (1..3, odd).

Ports:
- Clk  in  1  50 MHz system clock.
- Reset_n  in  1  reset, synchronous and active-low.
- VS  in  1  raw VGA vertical sync; active low, asynchronous to Clk.
- Continue  in  1  active-high button level, asynchronous to Clk.
- P1Score, P2Score  in  8  money collected this round (unsigned).
- P1Out, P2Out  in  1  player caught by car (level).
- Phase  out  3  encoded phase: TITLE=0, COUNTDOWN=1, PLAY=2, PAUSED=3, ROUND_END=4, GAME_OVER=5.
- RunEn  out  1  game objects may advance.
- ClearRound  out  1  one-Clk pulse; game reloads positions and scores.
- TimerBcd  out  8  {tens, ones} seconds remaining.
- Round  out  2  current round index.
- Wins1, Wins2  out  2  rounds won per player.
- Winner  out  2  none=00, P1=01, P2=10, tie=11; valid in GAME_OVER only, 00 otherwise.

## Operation
- **Input conditioning**
  - VS and Continue each pass through a 2-FF synchronizer.
  - FrameTick is a one-cycle pulse on the synchronized rising edge of VS (end of sync pulse).
  - Press is a one-cycle pulse on the synchronized rising edge of Continue.
- **Counters**
  - Frame counter counts FrameTick events. When it reaches FRAMES_PER_SEC-1 and another tick arrives, it wraps to 0 and issues SecTick.
  - The frame counter clears on every phase entry.
- **Timer**
  - TimerBcd decrements in BCD on SecTick: ones==0 gives ones=9 and tens-1.
  - The timer never decrements below 00.
- **Phase transitions**
  - TITLE: on Press, go to COUNTDOWN, pulse ClearRound, and set TimerBcd=COUNTDOWN_SECS.
  - COUNTDOWN: on a SecTick while TimerBcd==01, go to PLAY, set TimerBcd=ROUND_SECS in BCD, and set RunEn=1.
  - PLAY: the round ends on the SecTick that takes TimerBcd to 00, or when P1Out&&P2Out, whichever comes first. On exit, RunEn=0.
    - Score compare: higher score increments that player's Wins; equal scores increment neither.
    - Then go to ROUND_END with TimerBcd=ENDWAIT_SECS.
  - ROUND_END: on Press, or on a SecTick while TimerBcd==01:
    - Go to GAME_OVER if Round==ROUNDS-1, or if Wins1 or Wins2 > ROUNDS/2.
    - Otherwise Round+1, pulse ClearRound, go to COUNTDOWN.
  - GAME_OVER: Winner = comparison of Wins1 and Wins2. On Press, clear Round and both Wins, then go to TITLE.
- **Boundary conditions**
  - Timer expiry and both-out in the same cycle produce one round evaluation.
  - Press coinciding with the auto-advance SecTick in ROUND_END produces a single advance.
  - Press is ignored in COUNTDOWN.
  - Score inputs are sampled only in the PLAY-exit cycle.
  - A FrameTick in the same cycle as a phase entry is dropped.
  - Reset_n low at any point returns to the reset state on the next Clk edge, regardless of phase.
- **Reset values**
  - Phase=TITLE, RunEn=0, ClearRound=0, TimerBcd=8'h00, Round=0, Wins1=Wins2=0, Winner=00.
  - Synchronizers and counters are cleared.

## Timing
- All outputs are registered.
- Continue rising at Clk edge n: Press asserts in cycle n+3. The Phase, ClearRound and TimerBcd updates are visible after edge n+4.
- VS rising edge to FrameTick: same 3-cycle synchronizer latency.
- PLAY exit: Wins, RunEn=0 and Phase=ROUND_END all update on the same edge.
- ClearRound is exactly one Clk wide.
- Inputs must hold at least 3 Clk to be seen. VS is far slower than Clk, so this always holds for VS.

## Configuration
- GAME_SEQ_PAUSE_EN defined:
  - Press in PLAY goes to PAUSED: RunEn=0, timer and frame counter frozen, P1Out/P2Out ignored.
  - Press in PAUSED returns to PLAY with the frame counter preserved; the no-clear-on-entry exception applies.
- GAME_SEQ_PAUSE_EN undefined: PAUSED is unreachable and Press is ignored in PLAY.

## Structure
- Package game_seq_pkg holds:
  - phase_t enum with the encodings above.
  - Winner encodings.
  - A BCD helper function that converts a 0..99 constant to {tens, ones}.
- Sub-module bcd_down_timer: load value, decrement enable, zero and one flags. It is used for the countdown, round and end-wait timers.
- Synchronizers, edge detectors and the FSM stay in game_sequencer.

## Test plan
Test parameters: FRAMES_PER_SEC=2, COUNTDOWN_SECS=3, ROUND_SECS=12, ENDWAIT_SECS=1, ROUNDS=3.
- **Reset and start:** Reset_n low 2 cycles -> all reset values. Press -> Phase=1, one ClearRound pulse, TimerBcd=03. After 6 FrameTicks -> Phase=2, TimerBcd=12, RunEn=1.
- **BCD wrap and expiry:** in PLAY, 6 FrameTicks -> TimerBcd 12 -> 11 -> 10 -> 09. With P1Score=5, P2Score=3, continue to 00 -> Phase=4, Wins1=1, RunEn=0.
- **Simultaneous end:** P1Out=P2Out=1 on the same cycle as the SecTick reaching 00 -> single evaluation, Wins total +1 only. Equal scores -> no increment.
- **Early match end:** P1 wins rounds 0 and 1 -> from ROUND_END after round 1, Phase=5, Winner=01, Round=1. Press -> TITLE with Wins cleared.
- **Mid-operation reset:** Reset_n low during PLAY with TimerBcd=07 -> next edge Phase=0, TimerBcd=00, RunEn=0.
- **Pause (GAME_SEQ_PAUSE_EN):** Press in PLAY -> Phase=3, RunEn=0. 10 FrameTicks leave TimerBcd unchanged. Press -> Phase=2 and the timer resumes. Without the macro, Press in PLAY leaves Phase=2.

Source files
------------

// File: rtl/game_seq_pkg.sv
// Shared types, widths and helpers for the Crossy Robbers round/phase sequencer.
package game_seq_pkg;

  localparam int unsigned PHASE_W = 3;
  localparam int unsigned BCD_W   = 8;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned FCNT_W  = 8;

  typedef enum logic [PHASE_W-1:0] {
    PH_TITLE     = 3'd0,
    PH_COUNTDOWN = 3'd1,
    PH_PLAY      = 3'd2,
    PH_PAUSED    = 3'd3,
    PH_ROUND_END = 3'd4,
    PH_GAME_OVER = 3'd5
  } phase_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // Converts a 0..99 constant to packed {tens, ones} BCD.
  function automatic logic [BCD_W-1:0] to_bcd(input int unsigned v);
    return {NIB_W'((v / 10) % 10), NIB_W'(v % 10)};
  endfunction

endpackage

// File: rtl/game_sequencer_bcd_down_timer.sv
// Two-digit BCD seconds down-counter shared by the countdown, round and end-wait timers.
module bcd_down_timer
  import game_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             dec,
  output logic [BCD_W-1:0] value,
  output logic             zero_c,
  output logic             one_c
);

  logic [BCD_W-1:0] value_q, value_d;

  assign zero_c = (value_q == '0);
  assign one_c  = (value_q == BCD_W'(1));
  assign value  = value_q;

  // Load wins over decrement; the count saturates at 00.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (dec && !zero_c) begin
      if (value_q[NIB_W-1:0] == '0) begin
        value_d = {value_q[BCD_W-1:NIB_W] - NIB_W'(1), NIB_W'(9)};
      end else begin
        value_d = {value_q[BCD_W-1:NIB_W], value_q[NIB_W-1:0] - NIB_W'(1)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Round/phase controller: frame-tick derivation, phase FSM, round timer and win tracking.
// Optional pause support is enabled by defining GAME_SEQ_PAUSE_EN.
module game_sequencer
  import game_seq_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned COUNTDOWN_SECS = 3,
  parameter int unsigned ROUND_SECS     = 60,
  parameter int unsigned ENDWAIT_SECS   = 2,
  parameter int unsigned ROUNDS         = 3
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       VS,
  input  logic       Continue,
  input  logic [7:0] P1Score,
  input  logic [7:0] P2Score,
  input  logic       P1Out,
  input  logic       P2Out,
  output logic [2:0] Phase,
  output logic       RunEn,
  output logic       ClearRound,
  output logic [7:0] TimerBcd,
  output logic [1:0] Round,
  output logic [1:0] Wins1,
  output logic [1:0] Wins2,
  output logic [1:0] Winner
);

  localparam logic [FCNT_W-1:0] FRAME_LAST  = FCNT_W'(FRAMES_PER_SEC - 1);
  localparam logic [BCD_W-1:0]  CD_BCD      = to_bcd(COUNTDOWN_SECS);
  localparam logic [BCD_W-1:0]  ROUND_BCD   = to_bcd(ROUND_SECS);
  localparam logic [BCD_W-1:0]  ENDWAIT_BCD = to_bcd(ENDWAIT_SECS);
  localparam logic [1:0]        ROUND_LAST  = 2'(ROUNDS - 1);
  localparam logic [1:0]        WINS_MAJ    = 2'(ROUNDS / 2);

  logic vs_meta_q, vs_sync_q, vs_prev_q, frame_tick_q, frame_tick_d;
  logic cont_meta_q, cont_sync_q, cont_prev_q, press_q, press_d;

  phase_t            state_q, state_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [1:0]        round_q, round_d, wins1_q, wins1_d, wins2_q, wins2_d;
  logic [1:0]        winner_q, winner_d;
  logic              run_en_q, run_en_d, clear_round_q, clear_round_d;

  logic             sec_tick, keep_frames, round_over, match_over;
  logic             tmr_load, tmr_dec, tmr_zero_c, tmr_one_c;
  logic [BCD_W-1:0] tmr_load_val, tmr_value;

  bcd_down_timer u_timer (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .value    (tmr_value),
    .zero_c   (tmr_zero_c),
    .one_c    (tmr_one_c)
  );

  // Rising edges of the synchronized VS (end of sync) and Continue.
  always_comb begin
    frame_tick_d = vs_sync_q & ~vs_prev_q;
    press_d      = cont_sync_q & ~cont_prev_q;
  end

  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    round_d       = round_q;
    wins1_d       = wins1_q;
    wins2_d       = wins2_q;
    clear_round_d = 1'b0;
    tmr_load      = 1'b0;
    tmr_load_val  = '0;
    tmr_dec       = 1'b0;
    keep_frames   = 1'b0;
    sec_tick      = frame_tick_q && (frame_cnt_q == FRAME_LAST);
    round_over    = (sec_tick && tmr_one_c) || (P1Out && P2Out);
    match_over    = (round_q == ROUND_LAST) || (wins1_q > WINS_MAJ) || (wins2_q > WINS_MAJ);

    if (frame_tick_q) begin
      frame_cnt_d = sec_tick ? '0 : frame_cnt_q + FCNT_W'(1);
    end

    case (state_q)
      PH_TITLE: begin
        if (press_q) begin
          state_d       = PH_COUNTDOWN;
          clear_round_d = 1'b1;
          tmr_load      = 1'b1;
          tmr_load_val  = CD_BCD;
        end
      end
      PH_COUNTDOWN: begin
        if (sec_tick && tmr_one_c) begin
          state_d      = PH_PLAY;
          tmr_load     = 1'b1;
          tmr_load_val = ROUND_BCD;
        end else begin
          tmr_dec = sec_tick && !tmr_zero_c;
        end
      end
      PH_PLAY: begin
        // Expiry and both-out share one evaluation; scores are sampled only here.
        if (round_over) begin
          if (P1Score > P2Score) begin
            wins1_d = wins1_q + 2'd1;
          end else if (P2Score > P1Score) begin
            wins2_d = wins2_q + 2'd1;
          end
          state_d      = PH_ROUND_END;
          tmr_load     = 1'b1;
          tmr_load_val = ENDWAIT_BCD;
        end else begin
          tmr_dec = sec_tick && !tmr_zero_c;
`ifdef GAME_SEQ_PAUSE_EN
          if (press_q) begin
            state_d     = PH_PAUSED;
            keep_frames = 1'b1;
          end
`endif
        end
      end
`ifdef GAME_SEQ_PAUSE_EN
      PH_PAUSED: begin
        frame_cnt_d = frame_cnt_q;
        if (press_q) begin
          state_d     = PH_PLAY;
          keep_frames = 1'b1;
        end
      end
`endif
      PH_ROUND_END: begin
        if (press_q || (sec_tick && tmr_one_c)) begin
          if (match_over) begin
            state_d = PH_GAME_OVER;
          end else begin
            state_d       = PH_COUNTDOWN;
            round_d       = round_q + 2'd1;
            clear_round_d = 1'b1;
            tmr_load      = 1'b1;
            tmr_load_val  = CD_BCD;
          end
        end else begin
          tmr_dec = sec_tick && !tmr_zero_c;
        end
      end
      PH_GAME_OVER: begin
        if (press_q) begin
          state_d = PH_TITLE;
          round_d = '0;
          wins1_d = '0;
          wins2_d = '0;
        end
      end
      default: state_d = PH_TITLE;
    endcase

    // Phase entry restarts the second; pause/resume keeps the partial second.
    if ((state_d != state_q) && !keep_frames) begin
      frame_cnt_d = '0;
    end

    run_en_d = (state_d == PH_PLAY);
    winner_d = WIN_NONE;
    if (state_d == PH_GAME_OVER) begin
      if (wins1_d > wins2_d) begin
        winner_d = WIN_P1;
      end else if (wins2_d > wins1_d) begin
        winner_d = WIN_P2;
      end else begin
        winner_d = WIN_TIE;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vs_meta_q     <= 1'b0;
      vs_sync_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      frame_tick_q  <= 1'b0;
      cont_meta_q   <= 1'b0;
      cont_sync_q   <= 1'b0;
      cont_prev_q   <= 1'b0;
      press_q       <= 1'b0;
      state_q       <= PH_TITLE;
      frame_cnt_q   <= '0;
      round_q       <= '0;
      wins1_q       <= '0;
      wins2_q       <= '0;
      winner_q      <= WIN_NONE;
      run_en_q      <= 1'b0;
      clear_round_q <= 1'b0;
    end else begin
      vs_meta_q     <= VS;
      vs_sync_q     <= vs_meta_q;
      vs_prev_q     <= vs_sync_q;
      frame_tick_q  <= frame_tick_d;
      cont_meta_q   <= Continue;
      cont_sync_q   <= cont_meta_q;
      cont_prev_q   <= cont_sync_q;
      press_q       <= press_d;
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      round_q       <= round_d;
      wins1_q       <= wins1_d;
      wins2_q       <= wins2_d;
      winner_q      <= winner_d;
      run_en_q      <= run_en_d;
      clear_round_q <= clear_round_d;
    end
  end

  assign Phase      = state_q;
  assign RunEn      = run_en_q;
  assign ClearRound = clear_round_q;
  assign TimerBcd   = tmr_value;
  assign Round      = round_q;
  assign Wins1      = wins1_q;
  assign Wins2      = wins2_q;
  assign Winner     = winner_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios plus random play against an event-level model.
module tb_game_sequencer;

  localparam int FPS = 2;
  localparam int CDS = 3;
  localparam int RS  = 12;
  localparam int EWS = 1;
  localparam int NR  = 3;
`ifdef GAME_SEQ_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs = 1'b1;
  logic       cont = 1'b0;
  logic       p1_out = 1'b0;
  logic       p2_out = 1'b0;
  logic [7:0] p1_score = 8'd0;
  logic [7:0] p2_score = 8'd0;
  logic [2:0] phase;
  logic       run_en, clear_round;
  logic [7:0] timer_bcd;
  logic [1:0] round, wins1, wins2, winner;

  int n_checks = 0;
  int n_errors = 0;
  int n_clr = 0;
  int m_phase, m_secs, m_frames, m_round, m_w1, m_w2;
  int m_clr = 0;

  game_sequencer #(
    .FRAMES_PER_SEC (FPS),
    .COUNTDOWN_SECS (CDS),
    .ROUND_SECS     (RS),
    .ENDWAIT_SECS   (EWS),
    .ROUNDS         (NR)
  ) dut (
    .Clk        (clk),
    .Reset_n    (rst_n),
    .VS         (vs),
    .Continue   (cont),
    .P1Score    (p1_score),
    .P2Score    (p2_score),
    .P1Out      (p1_out),
    .P2Out      (p2_out),
    .Phase      (phase),
    .RunEn      (run_en),
    .ClearRound (clear_round),
    .TimerBcd   (timer_bcd),
    .Round      (round),
    .Wins1      (wins1),
    .Wins2      (wins2),
    .Winner     (winner)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clear_round === 1'b1) n_clr++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- event-level reference model ----------------
  task automatic m_reset();
    m_phase = 0; m_secs = 0; m_frames = 0; m_round = 0; m_w1 = 0; m_w2 = 0;
  endtask

  task automatic m_enter(input int ph, input int secs);
    m_phase = ph; m_secs = secs; m_frames = 0;
    if (ph == 1) m_clr++;
  endtask

  task automatic m_eval();
    if (p1_score > p2_score) m_w1++;
    else if (p2_score > p1_score) m_w2++;
    m_enter(4, EWS);
  endtask

  task automatic m_advance();
    if (m_round == NR - 1 || m_w1 > NR / 2 || m_w2 > NR / 2) m_phase = 5;
    else begin
      m_round++;
      m_enter(1, CDS);
    end
  endtask

  task automatic m_frame(input bit outs);
    bit sec;
    if (m_phase == 3) return;
    m_frames++;
    sec = (m_frames == FPS);
    if (sec) m_frames = 0;
    case (m_phase)
      1: if (sec) begin
           if (m_secs == 1) m_enter(2, RS); else m_secs--;
         end
      2: begin
           if (sec) m_secs--;
           if (m_secs == 0 || outs) m_eval();
         end
      4: if (sec) begin
           if (m_secs == 1) m_advance(); else m_secs--;
         end
      default: ;
    endcase
  endtask

  task automatic m_press();
    case (m_phase)
      0: m_enter(1, CDS);
      2: if (PAUSE_EN) m_phase = 3;
      3: m_phase = 2;
      4: m_advance();
      5: begin m_round = 0; m_w1 = 0; m_w2 = 0; m_phase = 0; end
      default: ;
    endcase
  endtask

  function automatic int exp_winner();
    if (m_phase != 5) return 0;
    if (m_w1 > m_w2) return 1;
    if (m_w2 > m_w1) return 2;
    return 3;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "/phase"}, 32'(phase), 32'(m_phase));
    check({tag, "/timer"}, 32'(timer_bcd), 32'((m_secs / 10) * 16 + (m_secs % 10)));
    check({tag, "/run_en"}, 32'(run_en), 32'(m_phase == 2));
    check({tag, "/round"}, 32'(round), 32'(m_round));
    check({tag, "/wins1"}, 32'(wins1), 32'(m_w1));
    check({tag, "/wins2"}, 32'(wins2), 32'(m_w2));
    check({tag, "/winner"}, 32'(winner), 32'(exp_winner()));
    check({tag, "/clear_pulses"}, 32'(n_clr), 32'(m_clr));
  endtask

  // ---------------- stimulus ----------------
  task automatic do_reset(input string tag);
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    m_reset();
    check_all(tag);
  endtask

  task automatic do_frame(input bit outs, input string tag);
    @(negedge clk) vs = 1'b0;
    repeat (4) @(negedge clk);
    vs = 1'b1;
    repeat (3) @(negedge clk);
    if (outs) begin p1_out = 1'b1; p2_out = 1'b1; end
    @(negedge clk);
    p1_out = 1'b0; p2_out = 1'b0;
    repeat (2 + $urandom_range(0, 4)) @(negedge clk);
    m_frame(outs);
    check_all(tag);
  endtask

  task automatic do_press(input string tag);
    @(negedge clk) cont = 1'b1;
    repeat (4) @(negedge clk);
    cont = 1'b0;
    repeat (5 + $urandom_range(0, 3)) @(negedge clk);
    m_press();
    check_all(tag);
  endtask

  task automatic do_press_timed();
    @(negedge clk) cont = 1'b1;
    repeat (3) @(negedge clk);
    check("press_lat_before", 32'(phase), 32'd0);
    @(negedge clk);
    check("press_lat_phase", 32'(phase), 32'd1);
    check("press_lat_clear", 32'(clear_round), 32'd1);
    @(negedge clk);
    check("clear_width", 32'(clear_round), 32'd0);
    repeat (2) @(negedge clk);
    cont = 1'b0;
    repeat (5) @(negedge clk);
    m_press();
    check_all("start");
  endtask

  task automatic do_outs(input string tag);
    @(negedge clk) begin p1_out = 1'b1; p2_out = 1'b1; end
    @(negedge clk) begin p1_out = 1'b0; p2_out = 1'b0; end
    repeat (3) @(negedge clk);
    if (m_phase == 2) m_eval();
    check_all(tag);
  endtask

  initial begin
    int r;
    m_reset();
    do_reset("reset");

    do_press_timed();
    repeat (2) do_frame(1'b0, "cd");
    do_press("cd_press_ignored");
    repeat (4) do_frame(1'b0, "cd");
    check("play_entry_timer", 32'(timer_bcd), 32'h12);

    p1_score = 8'd5; p2_score = 8'd3;
    repeat (24) do_frame(1'b0, "play0");
    check("r0_wins1", 32'(wins1), 32'd1);

    repeat (2) do_frame(1'b0, "endwait");
    repeat (6) do_frame(1'b0, "cd1");
    p1_score = 8'd7; p2_score = 8'd2;
    repeat (23) do_frame(1'b0, "play1");
    do_frame(1'b1, "simul_end");
    check("simul_wins_total", 32'(wins1) + 32'(wins2), 32'd2);

    do_press("early_over");
    check("early_winner", 32'(winner), 32'd1);
    check("early_round", 32'(round), 32'd1);
    do_press("go_to_title");

    do_press("start2");
    repeat (6) do_frame(1'b0, "cd2");
    p1_score = 8'd4; p2_score = 8'd4;
    repeat (23) do_frame(1'b0, "play_tie");
    do_frame(1'b1, "simul_tie");
    check("tie_wins_total", 32'(wins1) + 32'(wins2), 32'd0);

    do_press("adv_press");
    repeat (6) do_frame(1'b0, "cd3");
    do_frame(1'b0, "pre_pause");
    do_press("pause");
    repeat (10) do_frame(1'b0, "paused");
    do_press("resume");
    do_frame(1'b0, "resumed");
    for (int k = 0; k < 40 && m_phase == 2 && m_secs > 7; k++) do_frame(1'b0, "to_07");

    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    check("mrst_phase", 32'(phase), 32'd0);
    check("mrst_timer", 32'(timer_bcd), 32'd0);
    check("mrst_run_en", 32'(run_en), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(negedge clk);
    m_reset();
    check_all("mrst");

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        p1_score = 8'($urandom_range(0, 3));
        p2_score = 8'($urandom_range(0, 3));
      end else if (r < 22) begin
        do_press("rnd_press");
      end else if (r < 28) begin
        do_outs("rnd_outs");
      end else begin
        do_frame($urandom_range(0, 9) == 0, "rnd_frame");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
